td4_program_loader: RTL

//  Program-side partner of the CPU core: the CPU reads opcode/immediate by pc; this block writes and serves them.

---
 rtl/td4_program_loader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/td4_program_loader.sv
// td4_program_loader: 16x8 program memory for the TD4 CPU core.
// Words are loaded nibble-serially from pins through an asynchronous strobe.
// In RUN the memory serves {opcode, immediate} = mem[pc] to the CPU.
module td4_program_loader #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_en,
    input  logic                strobe,
    input  logic [DATA_W/2-1:0] data_nib,
    input  logic [ADDR_W-1:0]   pc,
    output logic [DATA_W/2-1:0] opcode,
    output logic [DATA_W/2-1:0] immediate,
    output logic                cpu_run,
    output logic [ADDR_W-1:0]   load_addr,
    output logic                load_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NIB_W = DATA_W / 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_HI = 2'd1,
        LOAD_LO = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [NIB_W-1:0]    hold;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                strobe_dly;
    logic                pulse;
    logic [DATA_W-1:0]   rd_word;

    // Synchronise the strobe pin and keep one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            strobe_dly <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], strobe};
            strobe_dly <= sync_q[SYNC_STAGES-1];
        end
    end

    // One-clock pulse per synchronised rising edge of strobe
    assign pulse = sync_q[SYNC_STAGES-1] & ~strobe_dly;

    // Load/run FSM with memory writes and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold      <= '0;
            load_addr <= '0;
            load_done <= 1'b0;
            cpu_run   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (load_en) begin
                        state     <= LOAD_HI;
                        load_addr <= '0;
                        load_done <= 1'b0;
                        cpu_run   <= 1'b0;
                    end else begin
                        state   <= RUN;
                        cpu_run <= 1'b1;
                    end
                end
                LOAD_HI: begin
                    // leaving load mode takes priority over a coincident nibble
                    if (!load_en) begin
                        state   <= RUN;
                        cpu_run <= 1'b1;
                    end else if (pulse) begin
                        hold  <= data_nib;
                        state <= LOAD_LO;
                    end
                end
                LOAD_LO: begin
                    if (!load_en) begin
                        state   <= RUN;
                        cpu_run <= 1'b1;
                    end else if (pulse) begin
                        mem[load_addr] <= {hold, data_nib};
                        load_addr      <= load_addr + 1'b1;
                        if (load_addr == '1) begin
                            load_done <= 1'b1;
                        end
                        state <= LOAD_HI;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cpu_run <= 1'b0;
                end
            endcase
        end
    end

    assign rd_word = mem[pc];

    // Zero-latency read path; cpu_run is the registered image of state==RUN
    always_comb begin
        opcode    = '0;
        immediate = '0;
        if (cpu_run) begin
            opcode    = rd_word[DATA_W-1:NIB_W];
            immediate = rd_word[NIB_W-1:0];
        end
    end

endmodule
